appr_mag_peak: RTL and testbench
================================

Name: appr_mag_peak

Overview:
Parametrised, pipelined successor to the single-mode approximate-magnitude unit in the OFDM RX path.
- Computes an alpha-max-plus-beta-min magnitude estimate of a complex sample, with a runtime-selectable coefficient mode.
- Tracks the peak magnitude and its index over fixed-length sample windows; the timing-sync / packet-detect logic uses this to locate correlation peaks.

Parameters:
WIDTH, 16, bit width of signed two's-complement real_in/imag_in
WIN_LOG2, 6, log2 of peak-search window length (window = 2^WIN_LOG2 valid samples)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
ena  input  1  input sample valid
mode  input  2  coefficient select, sampled together with the input sample
win_start  input  1  restart peak window
real_in  input  WIDTH  real part, signed
imag_in  input  WIDTH  imaginary part, signed
mag  output  WIDTH+1  magnitude estimate, unsigned
mag_val  output  1  mag valid strobe
peak_mag  output  WIDTH+1  largest mag of last completed window
peak_idx  output  WIN_LOG2  position of that peak within its window
peak_val  output  1  one-cycle strobe: peak_mag/peak_idx updated

Behaviour:
- Reset: all pipeline registers, mag, peak_mag, peak_idx, window counter and running peak are 0; mag_val and peak_val are 0. Reset overrides all other inputs. Reset mid-operation discards in-flight samples and any partial window.
- Pipeline: 3 registered stages; each stage advances only when its valid bit is set. A sample with ena=1 at cycle t produces mag_val=1 at cycle t+3. Bubbles (ena=0) propagate as valid=0, and mag holds its last value. Throughput is 1 sample/cycle.
- Stage 1: absolute value of each input, saturating. -2^(WIDTH-1) maps to 2^(WIDTH-1)-1; no wrap to negative. mode is registered alongside the data, so a mode change affects only samples presented with the new mode.
- Stage 2: max = larger abs, min = smaller abs. On equality, max = min = that value.
- Stage 3: mag = max + f(min), with truncating shifts.
  - mode 00: f = min>>1
  - mode 01: f = min>>2
  - mode 10: f = (min>>2)+(min>>3)
  - mode 11: f = min (L1 norm)
  - Result is WIDTH+1 bits and never overflows, since max+min <= 2^WIDTH-2.
- Peak tracker, clocked on mag_val:
  - Window counter cnt runs 0..2^WIN_LOG2-1.
  - When cnt==0, or when mag > run_peak (strict), set run_peak=mag and run_idx=cnt. Ties keep the earliest index.
  - On the valid sample with cnt==2^WIN_LOG2-1: on the next cycle peak_mag/peak_idx take the final run_peak/run_idx (including this sample) and peak_val pulses for exactly one cycle. cnt then wraps to 0.
  - peak_mag/peak_idx hold between windows.
- win_start:
  - Sets cnt to 0 and abandons the partial window; no peak_val is produced for it.
  - If mag_val is also high in the same cycle, that sample becomes index 0 of the new window.
  - Samples already in the pipeline are not flushed.
  - If win_start coincides with the last sample of a window, win_start wins: no peak_val, and the sample is index 0.
- peak_val and mag_val may both be high in the same cycle.

Test Plan:
- WIDTH=16. real=3, imag=-4 presented with modes 00/01/10/11 on consecutive cycles -> mag 5,4,4,7 on cycles t+3..t+6, with mag_val high on those four cycles only.
- Saturation: real=-32768, imag=0, mode 00 -> mag 32767. real=imag=-32768, mode 11 -> mag 65534. No negative wrap.
- Bubbles: ena pattern 1,0,0,1 with real=imag=10, mode 00 -> mag_val pattern 1,0,0,1 delayed 3 cycles, mag 15, and mag holds 15 during the gap.
- WIN_LOG2=2, mags 5,9,9,2 (mode 11, imag=0, real=5,9,9,2) -> peak_val single pulse one cycle after the 4th mag_val, with peak_mag=9, peak_idx=1 (earliest tie). A second window 1,1,1,8 -> peak_mag=8, peak_idx=3.
- win_start asserted after 2 valid samples of a window, then 4 further samples 3,7,1,0 -> no peak_val for the aborted window, then peak_mag=7, peak_idx=1.
- rst asserted for 1 cycle with 2 samples in flight -> no mag_val from those samples; all outputs 0 the cycle after reset; the next window starts at index 0.

Source files
------------

// File: rtl/appr_mag_peak_if.sv
// rtl/appr_mag_peak_if.sv - sample/result bus of the approximate-magnitude peak tracker
interface appr_mag_peak_if #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 6
);
  logic                       ena;
  logic [1:0]                 mode;
  logic                       win_start;
  logic signed [WIDTH-1:0]    real_in;
  logic signed [WIDTH-1:0]    imag_in;
  logic [WIDTH:0]             mag;
  logic                       mag_val;
  logic [WIDTH:0]             peak_mag;
  logic [WIN_LOG2-1:0]        peak_idx;
  logic                       peak_val;

  // Sample source side
  modport master (
    output ena, mode, win_start, real_in, imag_in,
    input  mag, mag_val, peak_mag, peak_idx, peak_val
  );

  // Magnitude/peak engine side
  modport slave (
    input  ena, mode, win_start, real_in, imag_in,
    output mag, mag_val, peak_mag, peak_idx, peak_val
  );
endinterface

// File: rtl/appr_mag_peak.sv
// rtl/appr_mag_peak.sv - pipelined alpha-max-plus-beta-min magnitude with windowed peak search
module appr_mag_peak #(
  parameter int WIDTH    = 16,
  parameter int WIN_LOG2 = 6
) (
  input  logic             clk,
  input  logic             rst,
  appr_mag_peak_if.slave   bus
);

  // Saturating absolute value: the most negative code clips to the largest positive one.
  function automatic logic [WIDTH-2:0] abs_sat(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] n;
    n = ~x + 1'b1;
    if (!x[WIDTH-1])
      return x[WIDTH-2:0];
    else if (x[WIDTH-2:0] == '0)
      return '1;
    else
      return n[WIDTH-2:0];
  endfunction

  // Stage 1: absolute values + mode
  logic                  v1_q;
  logic [WIDTH-2:0]      re1_q, im1_q;
  logic [1:0]            mode1_q;
  // Stage 2: max/min + mode
  logic                  v2_q;
  logic [WIDTH-2:0]      max2_q, min2_q;
  logic [1:0]            mode2_q;
  // Stage 3: magnitude
  logic                  v3_q;
  logic [WIDTH:0]        mag_q;
  // Peak tracker
  logic [WIN_LOG2-1:0]   cnt_q;
  logic [WIDTH:0]        run_peak_q;
  logic [WIN_LOG2-1:0]   run_idx_q;
  logic [WIDTH:0]        peak_mag_q;
  logic [WIN_LOG2-1:0]   peak_idx_q;
  logic                  peak_val_q;

  logic [WIDTH-2:0]      abs_re_d, abs_im_d;
  logic [WIDTH-2:0]      max_d, min_d, f_d;
  logic [WIDTH:0]        mag_d;
  logic [WIN_LOG2-1:0]   eff_cnt_d;
  logic                  take_d, close_d;
  logic [WIDTH:0]        new_peak_d;
  logic [WIN_LOG2-1:0]   new_idx_d;

  // Datapath combinational terms for each stage
  always_comb begin
    abs_re_d = abs_sat(bus.real_in);
    abs_im_d = abs_sat(bus.imag_in);
    max_d    = (re1_q >= im1_q) ? re1_q : im1_q;
    min_d    = (re1_q >= im1_q) ? im1_q : re1_q;
    case (mode2_q)
      2'b00:   f_d = min2_q >> 1;
      2'b01:   f_d = min2_q >> 2;
      2'b10:   f_d = (min2_q >> 2) + (min2_q >> 3);
      default: f_d = min2_q;
    endcase
    mag_d = {2'b00, max2_q} + {2'b00, f_d};
  end

  // Three-stage pipeline; data registers load only with their valid bit
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      re1_q   <= '0;
      im1_q   <= '0;
      mode1_q <= '0;
      v2_q    <= 1'b0;
      max2_q  <= '0;
      min2_q  <= '0;
      mode2_q <= '0;
      v3_q    <= 1'b0;
      mag_q   <= '0;
    end else begin
      v1_q <= bus.ena;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (bus.ena) begin
        re1_q   <= abs_re_d;
        im1_q   <= abs_im_d;
        mode1_q <= bus.mode;
      end
      if (v1_q) begin
        max2_q  <= max_d;
        min2_q  <= min_d;
        mode2_q <= mode1_q;
      end
      if (v2_q)
        mag_q <= mag_d;
    end
  end

  // Peak decision: win_start forces the current sample to index 0 and suppresses the close
  always_comb begin
    eff_cnt_d  = bus.win_start ? '0 : cnt_q;
    take_d     = (eff_cnt_d == '0) || (mag_q > run_peak_q);
    new_peak_d = take_d ? mag_q : run_peak_q;
    new_idx_d  = take_d ? eff_cnt_d : run_idx_q;
    close_d    = v3_q && !bus.win_start && (eff_cnt_d == '1);
  end

  // Window counter, running peak and published peak
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      run_peak_q <= '0;
      run_idx_q  <= '0;
      peak_mag_q <= '0;
      peak_idx_q <= '0;
      peak_val_q <= 1'b0;
    end else begin
      peak_val_q <= close_d;
      if (v3_q) begin
        run_peak_q <= new_peak_d;
        run_idx_q  <= new_idx_d;
        cnt_q      <= eff_cnt_d + 1'b1;
      end else if (bus.win_start) begin
        cnt_q <= '0;
      end
      if (close_d) begin
        peak_mag_q <= new_peak_d;
        peak_idx_q <= new_idx_d;
      end
    end
  end

  assign bus.mag      = mag_q;
  assign bus.mag_val  = v3_q;
  assign bus.peak_mag = peak_mag_q;
  assign bus.peak_idx = peak_idx_q;
  assign bus.peak_val = peak_val_q;

endmodule

// File: tb/tb_appr_mag_peak.sv
// tb/tb_appr_mag_peak.sv - scoreboard bench for appr_mag_peak
module tb_appr_mag_peak;
  localparam int WIDTH    = 16;
  localparam int WIN_LOG2 = 2;
  localparam int WIN      = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  appr_mag_peak_if #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2)) bus ();

  appr_mag_peak #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int mag_q[$];
  int pkm_q[$];
  int pki_q[$];

  int   last_mag = 0;
  int   last_pkm = 0;
  int   last_pki = 0;
  logic prev_mv  = 1'b0;

  bit [2:0] ws_sr = 3'b000;
  int w_cnt  = 0;
  int w_peak = 0;
  int w_idx  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_mag(input int re, input int im, input int md);
    int a, b, mx, mn;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    if (a > 32767) a = 32767;
    if (b > 32767) b = 32767;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    case (md)
      0:       return mx + mn / 2;
      1:       return mx + mn / 4;
      2:       return mx + mn / 4 + mn / 8;
      default: return mx + mn;
    endcase
  endfunction

  // One input slot. nw marks this slot's sample (or bubble) as the start of a new window;
  // the matching win_start pin is raised three slots later, when that slot reaches mag_val.
  task automatic slot(input bit en, input int re, input int im, input int md, input bit nw, input int want);
    int e;
    bus.win_start = ws_sr[2];
    ws_sr         = {ws_sr[1:0], nw};
    bus.ena       = en;
    bus.real_in   = re[15:0];
    bus.imag_in   = im[15:0];
    bus.mode      = md[1:0];
    if (nw) w_cnt = 0;
    if (en) begin
      e = (want >= 0) ? want : model_mag(re, im, md);
      mag_q.push_back(e);
      if (w_cnt == 0 || e > w_peak) begin
        w_peak = e;
        w_idx  = w_cnt;
      end
      if (w_cnt == WIN - 1) begin
        pkm_q.push_back(w_peak);
        pki_q.push_back(w_idx);
      end
      w_cnt = (w_cnt + 1) % WIN;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b0, 0, 0, 0, 1'b0, -1);
  endtask

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mag_val) begin
        if (mag_q.size() == 0) begin
          check_val("mag_val_extra", bus.mag_val, 0);
        end else begin
          last_mag = mag_q.pop_front();
          check_val("mag", bus.mag, last_mag);
        end
      end else begin
        check_val("mag_hold", bus.mag, last_mag);
      end
      if (bus.peak_val) begin
        if (pkm_q.size() == 0) begin
          check_val("peak_val_extra", bus.peak_val, 0);
        end else begin
          last_pkm = pkm_q.pop_front();
          last_pki = pki_q.pop_front();
          check_val("peak_mag", bus.peak_mag, last_pkm);
          check_val("peak_idx", bus.peak_idx, last_pki);
          check_val("peak_timing", prev_mv, 1);
        end
      end else begin
        check_val("peak_mag_hold", bus.peak_mag, last_pkm);
        check_val("peak_idx_hold", bus.peak_idx, last_pki);
      end
      prev_mv = bus.mag_val;
    end
  end

  initial begin
    int guard;
    bus.ena = 1'b0; bus.win_start = 1'b0; bus.mode = 2'b00;
    bus.real_in = '0; bus.imag_in = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_mag", bus.mag, 0);
    check_val("rst_mag_val", bus.mag_val, 0);
    check_val("rst_peak_mag", bus.peak_mag, 0);
    check_val("rst_peak_idx", bus.peak_idx, 0);
    check_val("rst_peak_val", bus.peak_val, 0);
    rst = 1'b0;

    // modes on consecutive cycles: 5,4,4,7 -> completes a window, peak 7 @3
    slot(1'b1, 3, -4, 0, 1'b1, 5);
    slot(1'b1, 3, -4, 1, 1'b0, 4);
    slot(1'b1, 3, -4, 2, 1'b0, 4);
    slot(1'b1, 3, -4, 3, 1'b0, 7);
    idle(4);

    // saturation
    slot(1'b1, -32768, 0, 0, 1'b1, 32767);
    slot(1'b1, -32768, -32768, 3, 1'b0, 65534);
    idle(3);

    // bubbles: mag holds 15 through the gap
    slot(1'b1, 10, 10, 0, 1'b1, 15);
    idle(2);
    slot(1'b1, 10, 10, 0, 1'b0, 15);
    idle(4);

    // two windows, earliest tie wins
    slot(1'b1, 5, 0, 3, 1'b1, 5);
    slot(1'b1, 9, 0, 3, 1'b0, 9);
    slot(1'b1, 9, 0, 3, 1'b0, 9);
    slot(1'b1, 2, 0, 3, 1'b0, 2);
    slot(1'b1, 1, 0, 3, 1'b0, 1);
    slot(1'b1, 1, 0, 3, 1'b0, 1);
    slot(1'b1, 1, 0, 3, 1'b0, 1);
    slot(1'b1, 8, 0, 3, 1'b0, 8);
    idle(3);

    // aborted window: win_start coincides with the third sample
    slot(1'b1, 20, 0, 3, 1'b1, 20);
    slot(1'b1, 30, 0, 3, 1'b0, 30);
    slot(1'b1, 3, 0, 3, 1'b1, 3);
    slot(1'b1, 7, 0, 3, 1'b0, 7);
    slot(1'b1, 1, 0, 3, 1'b0, 1);
    slot(1'b1, 0, 0, 3, 1'b0, 0);
    idle(3);

    // win_start on a bubble
    slot(1'b1, 40, 0, 3, 1'b1, 40);
    slot(1'b1, 50, 0, 3, 1'b0, 50);
    slot(1'b0, 0, 0, 0, 1'b1, -1);
    slot(1'b1, 6, 0, 3, 1'b0, 6);
    slot(1'b1, 2, 0, 3, 1'b0, 2);
    slot(1'b1, 6, 0, 3, 1'b0, 6);
    slot(1'b1, 1, 0, 3, 1'b0, 1);
    idle(3);

    // win_start coincides with the last sample of a window
    slot(1'b1, 1, 0, 3, 1'b1, 1);
    slot(1'b1, 2, 0, 3, 1'b0, 2);
    slot(1'b1, 3, 0, 3, 1'b0, 3);
    slot(1'b1, 9, 0, 3, 1'b1, 9);
    slot(1'b1, 4, 0, 3, 1'b0, 4);
    slot(1'b1, 12, 0, 3, 1'b0, 12);
    slot(1'b1, 2, 0, 3, 1'b0, 2);
    idle(3);

    // random samples and modes
    for (int i = 0; i < 12; i++) begin
      int re, im, md;
      re = int'($urandom_range(0, 65535)) - 32768;
      im = int'($urandom_range(0, 65535)) - 32768;
      md = int'($urandom_range(0, 3));
      slot(1'b1, re, im, md, (i == 0) || (i == 5), -1);
    end
    idle(4);

    // reset with two samples in flight
    slot(1'b1, 100, 0, 3, 1'b1, 100);
    slot(1'b1, 200, 0, 3, 1'b0, 200);
    bus.ena = 1'b0;
    bus.win_start = 1'b0;
    rst = 1'b1;
    mag_q.delete();
    pkm_q.delete();
    pki_q.delete();
    ws_sr = 3'b000;
    w_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_mag = 0; last_pkm = 0; last_pki = 0; prev_mv = 1'b0;
    check_val("post_rst_mag", bus.mag, 0);
    check_val("post_rst_mag_val", bus.mag_val, 0);
    check_val("post_rst_peak_mag", bus.peak_mag, 0);
    check_val("post_rst_peak_idx", bus.peak_idx, 0);
    check_val("post_rst_peak_val", bus.peak_val, 0);
    slot(1'b1, 2, 0, 3, 1'b0, 2);
    slot(1'b1, 3, 0, 3, 1'b0, 3);
    slot(1'b1, 1, 0, 3, 1'b0, 1);
    slot(1'b1, 3, 0, 3, 1'b0, 3);

    guard = 0;
    while ((mag_q.size() != 0 || pkm_q.size() != 0) && guard < 50) begin
      slot(1'b0, 0, 0, 0, 1'b0, -1);
      guard++;
    end
    idle(2);
    check_val("drain_mag", mag_q.size(), 0);
    check_val("drain_peak", pkm_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
